// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tristate_bus_arbiter                                         |
// | Description : Round-robin owner sequencer for a shared tristate bus with a |
// |               one-cycle all-off turnaround between owners and hold limit.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tristate_bus_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDX_W    = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] en,
   output logic [IDX_W-1:0] owner,
   output logic             busy
);

   localparam int                  c_HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
   localparam logic [IDX_W-1:0]    c_LAST_RST = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_last;
   logic [IDX_W-1:0]    r_owner;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic [N_REQ-1:0]    r_gnt;
   logic [N_REQ-1:0]    r_en;
   logic                r_busy;

   logic                w_found;
   logic [IDX_W-1:0]    w_win;
   logic [IDX_W-1:0]    w_cand;
   logic [N_REQ-1:0]    w_win_oh;
   logic [N_REQ-1:0]    w_owner_oh;
   logic                w_owner_req;
   logic                w_others;
   logic                w_hold_full;
   logic                w_release;

   // Search starts just past the previous owner, so it only wins again when alone.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_cand = IDX_W'((int'(r_last) + i) % N_REQ);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_comb begin
      w_win_oh          = '0;
      w_win_oh[w_win]   = 1'b1;
      w_owner_oh        = '0;
      w_owner_oh[r_owner] = 1'b1;
   end

   assign w_owner_req = req[r_owner];
   assign w_others    = |(req & ~w_owner_oh);
   assign w_hold_full = (r_hold_cnt == c_HOLD_MAX);
   assign w_release   = !w_owner_req || (w_hold_full && w_others);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_last     <= c_LAST_RST;
         r_owner    <= '0;
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_en       <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_TURN: begin
               if (w_found) begin
                  r_state    <= S_DRIVE;
                  r_owner    <= w_win;
                  r_gnt      <= w_win_oh;
                  r_en       <= w_win_oh;
                  r_busy     <= 1'b1;
                  r_hold_cnt <= c_HOLD_ONE;
               end else begin
                  r_state    <= S_IDLE;
                  r_gnt      <= '0;
                  r_en       <= '0;
                  r_busy     <= 1'b0;
                  r_hold_cnt <= '0;
               end
            end
            S_DRIVE: begin
               if (w_release) begin
                  r_state    <= S_TURN;
                  r_last     <= r_owner;
                  r_gnt      <= '0;
                  r_en       <= '0;
                  r_busy     <= 1'b0;
                  r_hold_cnt <= '0;
               end else if (w_hold_full) begin
                  // Sole requester at the limit keeps the bus with no turnaround gap.
                  r_hold_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_gnt      <= '0;
               r_en       <= '0;
               r_busy     <= 1'b0;
               r_hold_cnt <= '0;
            end
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign en    = r_en;
   assign owner = r_owner;
   assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tristate_bus_arbiter                                      |
// | Description : Scoreboard bench for tristate_bus_arbiter (N_REQ=4, HOLD=8). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tristate_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [3:0] en;
   logic [1:0] owner;
   logic       busy;

   typedef struct {
      int         cyc;
      logic [3:0] en;
      logic       busy;
   } exp_t;

   exp_t q[$];
   exp_t r_item;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   tristate_bus_arbiter #(
      .N_REQ    (4),
      .MAX_HOLD (8)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .gnt   (gnt),
      .en    (en),
      .owner (owner),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp_v);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   // Monitor: pops every expectation due this cycle and compares it.
   always @(negedge clk) begin
      check("onehot0_en", {31'd0, $onehot0(en)}, 32'd1);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         r_item = q.pop_front();
         check("slot_cycle", r_item.cyc, cyc);
         check("en", {28'd0, en}, {28'd0, r_item.en});
         check("gnt", {28'd0, gnt}, {28'd0, r_item.en});
         check("busy", {31'd0, busy}, {31'd0, r_item.busy});
         if (r_item.busy)
            check("owner", {30'd0, owner}, {30'd0, idx_of(r_item.en)});
      end
   end

   // Apply one input vector; the expectation is for the edge that samples it.
   task automatic vec(input logic r, input logic [3:0] rq, input logic [3:0] e_en, input logic e_busy);
      exp_t item;
      @(posedge clk);
      #1;
      rst = r;
      req = rq;
      item.cyc  = cyc + 1;
      item.en   = e_en;
      item.busy = e_busy;
      q.push_back(item);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain_timeout", q.size(), 32'd0);
   endtask

   initial begin
      // Reset held with all requests up, then round-robin through all four owners.
      repeat (2) vec(1'b0, 4'b1111, 4'b0000, 1'b0);
      for (int o = 0; o < 4; o++) begin
         repeat (8) vec(1'b1, 4'b1111, 4'(1 << o), 1'b1);
         vec(1'b1, 4'b1111, 4'b0000, 1'b0);
      end
      vec(1'b1, 4'b1111, 4'b0001, 1'b1);
      repeat (2) vec(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Single requester for three cycles.
      repeat (3) vec(1'b1, 4'b0100, 4'b0100, 1'b1);
      repeat (2) vec(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Sole requester past MAX_HOLD keeps the bus without a gap.
      repeat (20) vec(1'b1, 4'b0010, 4'b0010, 1'b1);
      repeat (2) vec(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Owner 0 drops while 1 and 3 wait: round-robin hands to 1.
      vec(1'b1, 4'b0001, 4'b0001, 1'b1);
      vec(1'b1, 4'b1011, 4'b0001, 1'b1);
      vec(1'b1, 4'b1010, 4'b0000, 1'b0);
      repeat (3) vec(1'b1, 4'b1010, 4'b0010, 1'b1);

      // Asynchronous reset between edges while driving.
      drain();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_en", {28'd0, en}, 32'd0);
      check("async_rst_gnt", {28'd0, gnt}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      vec(1'b0, 4'b1010, 4'b0000, 1'b0);
      vec(1'b1, 4'b1010, 4'b0010, 1'b1);
      vec(1'b1, 4'b1000, 4'b0000, 1'b0);
      vec(1'b1, 4'b1000, 4'b1000, 1'b1);
      repeat (2) vec(1'b1, 4'b0000, 4'b0000, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
